// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Merges ALU and load-unit register writes through a small FIFO
//            into one register-file write port, with read-hazard flags.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
   parameter int DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_alu_valid,
   input  logic [3:0]  i_alu_reg,
   input  logic [15:0] i_alu_data,
   output logic        o_alu_ready,
   input  logic        i_mem_valid,
   input  logic [3:0]  i_mem_reg,
   input  logic [15:0] i_mem_data,
   output logic        o_mem_ready,
   input  logic        i_hold,
   output logic        o_we,
   output logic [3:0]  o_wr_reg,
   output logic [15:0] o_in_data,
   input  logic [3:0]  i_read_a,
   input  logic [3:0]  i_read_b,
   input  logic [3:0]  i_read_c,
   output logic        o_haz_a,
   output logic        o_haz_b,
   output logic        o_haz_c,
   output logic [3:0]  o_count
);

   localparam int         c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] c_DEPTH = 4'(DEPTH);

   logic [3:0]         r_reg  [DEPTH];
   logic [15:0]        r_data [DEPTH];
   logic [DEPTH-1:0]   r_valid;
   logic [c_PTR_W-1:0] r_wptr;
   logic [c_PTR_W-1:0] r_rptr;
   logic [3:0]         r_count;
   logic               r_we;
   logic [3:0]         r_wr_reg;
   logic [15:0]        r_in_data;

   logic [3:0]         w_free;
   logic               w_mem_push;
   logic               w_alu_push;
   logic               w_pop;
   logic [c_PTR_W-1:0] w_wptr_p1;
   logic [c_PTR_W-1:0] w_alu_slot;
   logic [c_PTR_W-1:0] w_wptr_nxt;
   logic [3:0]         w_count_nxt;

   // Free space comes from registered count only: a pop this cycle gives no credit.
   assign w_free      = c_DEPTH - r_count;
   assign o_mem_ready = (w_free != 4'd0);
   assign o_alu_ready = (w_free >= 4'd2) || ((w_free == 4'd1) && !i_mem_valid);

   assign w_mem_push  = i_mem_valid && o_mem_ready;
   assign w_alu_push  = i_alu_valid && o_alu_ready;
   assign w_pop       = (r_count != 4'd0) && !i_hold;

   // MEM takes the first free slot, so it is issued ahead of a same-edge ALU push.
   assign w_wptr_p1   = r_wptr + c_PTR_W'(1);
   assign w_alu_slot  = w_mem_push ? w_wptr_p1 : r_wptr;
   assign w_wptr_nxt  = (w_mem_push && w_alu_push) ? (w_wptr_p1 + c_PTR_W'(1)) :
                        (w_mem_push || w_alu_push) ? w_wptr_p1 : r_wptr;
   assign w_count_nxt = r_count + 4'(w_mem_push) + 4'(w_alu_push) - 4'(w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= 4'd0;
         r_valid   <= '0;
         r_we      <= 1'b0;
         r_wr_reg  <= 4'd0;
         r_in_data <= 16'h0000;
         for (int i = 0; i < DEPTH; i++) begin
            r_reg[i]  <= 4'd0;
            r_data[i] <= 16'h0000;
         end
      end else begin
         r_we <= w_pop;
         if (w_pop) begin
            r_wr_reg        <= r_reg[r_rptr];
            r_in_data       <= r_data[r_rptr];
            r_valid[r_rptr] <= 1'b0;
            r_rptr          <= r_rptr + c_PTR_W'(1);
         end
         if (w_mem_push) begin
            r_reg[r_wptr]   <= i_mem_reg;
            r_data[r_wptr]  <= i_mem_data;
            r_valid[r_wptr] <= 1'b1;
         end
         if (w_alu_push) begin
            r_reg[w_alu_slot]   <= i_alu_reg;
            r_data[w_alu_slot]  <= i_alu_data;
            r_valid[w_alu_slot] <= 1'b1;
         end
         r_wptr  <= w_wptr_nxt;
         r_count <= w_count_nxt;
      end
   end

   // A register stays hazardous until its write has been on the port.
   always_comb begin
      o_haz_a = r_we && (r_wr_reg == i_read_a);
      o_haz_b = r_we && (r_wr_reg == i_read_b);
      o_haz_c = r_we && (r_wr_reg == i_read_c);
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && (r_reg[i] == i_read_a)) o_haz_a = 1'b1;
         if (r_valid[i] && (r_reg[i] == i_read_b)) o_haz_b = 1'b1;
         if (r_valid[i] && (r_reg[i] == i_read_c)) o_haz_c = 1'b1;
      end
   end

   assign o_we      = r_we;
   assign o_wr_reg  = r_wr_reg;
   assign o_in_data = r_in_data;
   assign o_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed and random stimulus against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_alu_valid, i_mem_valid, i_hold;
   logic [3:0]  i_alu_reg, i_mem_reg;
   logic [15:0] i_alu_data, i_mem_data;
   logic [3:0]  i_read_a, i_read_b, i_read_c;
   logic        o_alu_ready, o_mem_ready, o_we;
   logic [3:0]  o_wr_reg, o_count;
   logic [15:0] o_in_data;
   logic        o_haz_a, o_haz_b, o_haz_c;

   regfile_writeback #(.DEPTH(DEPTH)) u_dut (
      .i_clk(clk), .i_rst_n(i_rst_n),
      .i_alu_valid(i_alu_valid), .i_alu_reg(i_alu_reg), .i_alu_data(i_alu_data),
      .o_alu_ready(o_alu_ready),
      .i_mem_valid(i_mem_valid), .i_mem_reg(i_mem_reg), .i_mem_data(i_mem_data),
      .o_mem_ready(o_mem_ready),
      .i_hold(i_hold), .o_we(o_we), .o_wr_reg(o_wr_reg), .o_in_data(o_in_data),
      .i_read_a(i_read_a), .i_read_b(i_read_b), .i_read_c(i_read_c),
      .o_haz_a(o_haz_a), .o_haz_b(o_haz_b), .o_haz_c(o_haz_c),
      .o_count(o_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   ent_t        q[$];
   logic        m_we;
   logic [3:0]  m_wr;
   logic [15:0] m_dat;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz(input logic [3:0] idx);
      logic h;
      h = m_we && (m_wr == idx);
      foreach (q[i]) if (q[i].r == idx) h = 1'b1;
      return h;
   endfunction

   // Called at a falling edge: drive, check the settled outputs, advance the model over one rising edge.
   task automatic cycle(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                        input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic hd, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc);
      int   free;
      logic exp_mr, exp_ar;
      i_mem_valid = mv; i_mem_reg = mr; i_mem_data = md;
      i_alu_valid = av; i_alu_reg = ar; i_alu_data = ad;
      i_hold = hd; i_read_a = ra; i_read_b = rb; i_read_c = rc;
      #1;
      free   = DEPTH - q.size();
      exp_mr = (free >= 1);
      exp_ar = (free >= 2) || (free == 1 && !mv);
      check_val("mem_ready", o_mem_ready, exp_mr);
      check_val("alu_ready", o_alu_ready, exp_ar);
      check_val("count", o_count, q.size());
      check_val("we", o_we, m_we);
      check_val("wr_reg", o_wr_reg, m_wr);
      check_val("in_data", o_in_data, m_dat);
      check_val("haz_a", o_haz_a, model_haz(ra));
      check_val("haz_b", o_haz_b, model_haz(rb));
      check_val("haz_c", o_haz_c, model_haz(rc));
      if (q.size() > 0 && !hd) begin
         m_we  = 1'b1;
         m_wr  = q[0].r;
         m_dat = q[0].d;
         void'(q.pop_front());
      end else begin
         m_we = 1'b0;
      end
      if (mv && exp_mr) q.push_back(ent_t'({mr, md}));
      if (av && exp_ar) q.push_back(ent_t'({ar, ad}));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic hd, input logic [3:0] rb);
      cycle(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, hd, 4'd0, rb, 4'd15);
   endtask

   // Asserts reset away from any clock edge and checks the cleared state before and after an edge.
   task automatic reset_mid();
      i_mem_valid = 1'b1; i_alu_valid = 1'b1; i_hold = 1'b0;
      if (q.size() > 0) i_read_a = q[0].r;
      #2;
      i_rst_n = 1'b0;
      #1;
      q.delete();
      m_we = 1'b0; m_wr = 4'd0; m_dat = 16'h0000;
      check_val("rst_count", o_count, 0);
      check_val("rst_we", o_we, 0);
      check_val("rst_wr_reg", o_wr_reg, 0);
      check_val("rst_in_data", o_in_data, 0);
      check_val("rst_haz_a", o_haz_a, 0);
      check_val("rst_haz_b", o_haz_b, 0);
      check_val("rst_haz_c", o_haz_c, 0);
      @(posedge clk);
      @(negedge clk);
      check_val("rst_hold_we", o_we, 0);
      check_val("rst_hold_count", o_count, 0);
      i_rst_n = 1'b1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_alu_valid = 1'b0; i_alu_reg = 4'd0; i_alu_data = 16'h0;
      i_mem_valid = 1'b0; i_mem_reg = 4'd0; i_mem_data = 16'h0;
      i_hold = 1'b0; i_read_a = 4'd0; i_read_b = 4'd0; i_read_c = 4'd0;
      m_we = 1'b0; m_wr = 4'd0; m_dat = 16'h0000;
      #1;
      check_val("init_count", o_count, 0);
      check_val("init_we", o_we, 0);
      check_val("init_in_data", o_in_data, 0);
      @(negedge clk);
      i_rst_n = 1'b1;

      // Single ALU write to R3
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234, 1'b0, 4'd3, 4'd0, 4'd0);
      idle(1'b0, 4'd3);
      check_val("single_we", o_we, 1);
      check_val("single_reg", o_wr_reg, 3);
      check_val("single_data", o_in_data, 16'h1234);
      idle(1'b0, 4'd3);
      check_val("single_we_off", o_we, 0);

      // Dual push: MEM R1 issues before ALU R2
      cycle(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'h5555, 1'b1, 4'd1, 4'd2, 4'd0);
      check_val("dual_count2", o_count, 2);
      idle(1'b0, 4'd2);
      check_val("dual_first", o_wr_reg, 1);
      check_val("dual_count1", o_count, 1);
      idle(1'b0, 4'd2);
      check_val("dual_second", o_wr_reg, 2);
      check_val("dual_count0", o_count, 0);
      idle(1'b0, 4'd0);

      // Fill under hold, then release with requests presented
      cycle(1'b1, 4'd4, 16'h0404, 1'b1, 4'd5, 16'h0505, 1'b1, 4'd4, 4'd5, 4'd6);
      cycle(1'b1, 4'd6, 16'h0606, 1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd4, 4'd5, 4'd15);
      check_val("full_count", o_count, 4);
      check_val("full_mem_ready", o_mem_ready, 0);
      check_val("full_alu_ready", o_alu_ready, 0);
      cycle(1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0909, 1'b0, 4'd4, 4'd5, 4'd15);
      check_val("release_we", o_we, 1);
      cycle(1'b1, 4'd8, 16'h0808, 1'b0, 4'd9, 16'h0909, 1'b0, 4'd4, 4'd8, 4'd15);
      repeat (6) idle(1'b0, 4'd15);

      // Hazard on pending R7 through its write cycle
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd0, 4'd7, 4'd0);
      idle(1'b1, 4'd7);
      idle(1'b0, 4'd7);
      check_val("haz_we_cycle", o_haz_b, 1);
      idle(1'b0, 4'd7);
      check_val("haz_cleared", o_haz_b, 0);

      // Contention at count 3
      cycle(1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd11, 16'h0B0B, 1'b1, 4'd0, 4'd0, 4'd0);
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd12, 16'h0C0C, 1'b1, 4'd0, 4'd0, 4'd0);
      cycle(1'b1, 4'd13, 16'h0D0D, 1'b1, 4'd14, 16'h0E0E, 1'b0, 4'd0, 4'd0, 4'd0);
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd14, 16'h0E0E, 1'b0, 4'd0, 4'd0, 4'd0);
      repeat (6) idle(1'b0, 4'd14);

      // Reset with three entries pending
      cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1, 4'd1, 4'd2, 4'd3);
      cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h3333, 1'b1, 4'd1, 4'd2, 4'd3);
      check_val("pre_rst_count", o_count, 3);
      reset_mid();
      repeat (3) idle(1'b0, 4'd2);

      // Random traffic with a reset in the middle
      for (int n = 0; n < 600; n++) begin
         if (n == 300) reset_mid();
         cycle(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom),
               ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), 16'($urandom),
               ($urandom_range(0, 3) == 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
